// File: rtl/chf_pll_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: state encoding,
// Avalon register map of pll_cfg and the default counter words.
package chf_pll_pkg;

   // Write states are declared in issue order; the sequencer steps through them by increment.
   typedef enum logic [3:0] {
      S_IDLE,
      S_W_MODE,
      S_W_N,
      S_W_M,
      S_W_C0,
      S_W_MFRAC,
      S_W_START,
      S_WAIT_UNLOCK,
      S_WAIT_LOCK,
      S_HOLD
   } state_t;

   localparam logic [5:0] ADDR_MODE  = 6'd0;
   localparam logic [5:0] ADDR_START = 6'd2;
   localparam logic [5:0] ADDR_N     = 6'd3;
   localparam logic [5:0] ADDR_M     = 6'd4;
   localparam logic [5:0] ADDR_C0    = 6'd5;
   localparam logic [5:0] ADDR_MFRAC = 6'd7;

   localparam logic [31:0] DEF_N_CNT      = 32'h0001_0000;
   localparam logic [31:0] DEF_M_CNT      = 32'h0000_0404;
   localparam logic [31:0] DEF_C0_NTSC    = 32'h0000_0505;
   localparam logic [31:0] DEF_C0_PAL     = 32'h0002_0504;
   localparam logic [31:0] DEF_MFRAC_NTSC = 32'h9745_BF27;
   localparam logic [31:0] DEF_MFRAC_PAL  = 32'hA3D7_09E8;

endpackage

// File: rtl/chf_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module chf_sync2 (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: non-blocking assignments make meta and q a true two-stage shift; blocking would collapse them into one flop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/chf_pll_reconfig.sv
// Reprograms the video PLL over Avalon-MM when the NTSC/PAL selection changes, holding tv_reset meanwhile.
// Optional feature macro: CHF_PLLCFG_LOCK_WAIT_EN (unlock/lock wait states, lock timeout, lock_err).
module chf_pll_reconfig
   import chf_pll_pkg::*;
#(
   parameter logic [31:0] N_CNT        = DEF_N_CNT,
   parameter logic [31:0] M_CNT        = DEF_M_CNT,
   parameter logic [31:0] C0_NTSC      = DEF_C0_NTSC,
   parameter logic [31:0] C0_PAL       = DEF_C0_PAL,
   parameter logic [31:0] MFRAC_NTSC   = DEF_MFRAC_NTSC,
   parameter logic [31:0] MFRAC_PAL    = DEF_MFRAC_PAL,
   parameter int unsigned LOCK_TIMEOUT = 1_000_000,
   parameter int unsigned HOLD_CYCLES  = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pal,
   input  logic        pll_locked,
   input  logic        mgmt_waitrequest,
   output logic        mgmt_write,
   output logic [5:0]  mgmt_address,
   output logic [31:0] mgmt_writedata,
   output logic        tv_reset,
   output logic        busy,
   output logic        cur_pal,
   output logic        lock_err
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);

   state_t        state;
   state_t        next_wr;
   logic          target;
   logic          pal_s;
   logic [HW-1:0] hold_cnt;

   chf_sync2 u_sync_pal (.clk(clk), .reset_n(reset_n), .d(pal), .q(pal_s));

`ifdef CHF_PLLCFG_LOCK_WAIT_EN
   localparam int TW = $clog2(LOCK_TIMEOUT + 1);

   logic          locked_s;
   logic          tmo_hit;
   logic [TW-1:0] tmo_cnt;

   chf_sync2 u_sync_lock (.clk(clk), .reset_n(reset_n), .d(pll_locked), .q(locked_s));

   assign tmo_hit = (tmo_cnt == TW'(LOCK_TIMEOUT - 1));
`else
   logic unused_locked;
   assign unused_locked = pll_locked;
   assign lock_err      = 1'b0;
`endif

   assign next_wr = state_t'(state + 4'd1);

   function automatic logic [5:0] wr_addr(input state_t s);
      case (s)
         S_W_N:     return ADDR_N;
         S_W_M:     return ADDR_M;
         S_W_C0:    return ADDR_C0;
         S_W_MFRAC: return ADDR_MFRAC;
         S_W_START: return ADDR_START;
         default:   return ADDR_MODE;
      endcase
   endfunction

   function automatic logic [31:0] wr_data(input state_t s, input logic tgt);
      case (s)
         S_W_N:     return N_CNT;
         S_W_M:     return M_CNT;
         S_W_C0:    return tgt ? C0_PAL : C0_NTSC;
         S_W_MFRAC: return tgt ? MFRAC_PAL : MFRAC_NTSC;
         default:   return '0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         target         <= 1'b0;
         hold_cnt       <= '0;
         mgmt_write     <= 1'b0;
         mgmt_address   <= '0;
         mgmt_writedata <= '0;
         tv_reset       <= 1'b0;
         busy           <= 1'b0;
         cur_pal        <= 1'b0;
`ifdef CHF_PLLCFG_LOCK_WAIT_EN
         tmo_cnt        <= '0;
         lock_err       <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (pal_s != cur_pal) begin
                  target         <= pal_s;
                  state          <= S_W_MODE;
                  mgmt_write     <= 1'b1;
                  mgmt_address   <= ADDR_MODE;
                  mgmt_writedata <= '0;
                  tv_reset       <= 1'b1;
                  busy           <= 1'b1;
               end
            end
            // The accept cycle already loads the next write, so writes can go back-to-back.
            S_W_MODE, S_W_N, S_W_M, S_W_C0, S_W_MFRAC: begin
               if (!mgmt_waitrequest) begin
                  state          <= next_wr;
                  mgmt_address   <= wr_addr(next_wr);
                  mgmt_writedata <= wr_data(next_wr, target);
               end
            end
            S_W_START: begin
               if (!mgmt_waitrequest) begin
                  mgmt_write     <= 1'b0;
                  mgmt_address   <= '0;
                  mgmt_writedata <= '0;
`ifdef CHF_PLLCFG_LOCK_WAIT_EN
                  state          <= S_WAIT_UNLOCK;
                  tmo_cnt        <= '0;
`else
                  state          <= S_HOLD;
                  hold_cnt       <= '0;
                  cur_pal        <= target;
`endif
               end
            end
`ifdef CHF_PLLCFG_LOCK_WAIT_EN
            // A PLL that never drops lock simply runs out the timer here; that is not an error.
            S_WAIT_UNLOCK: begin
               if (!locked_s || tmo_hit) begin
                  state   <= S_WAIT_LOCK;
                  tmo_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            S_WAIT_LOCK: begin
               if (locked_s || tmo_hit) begin
                  if (!locked_s) lock_err <= 1'b1;
                  state    <= S_HOLD;
                  hold_cnt <= '0;
                  cur_pal  <= target;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
`endif
            S_HOLD: begin
               if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                  state    <= S_IDLE;
                  tv_reset <= 1'b0;
                  busy     <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: begin
               state      <= S_IDLE;
               mgmt_write <= 1'b0;
               tv_reset   <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chf_pll_reconfig.sv
// Bench for chf_pll_reconfig: directed timing checks plus randomized pal/waitrequest traffic
// scored against a queue of the Avalon writes each retune must issue.
module tb_chf_pll_reconfig;

   localparam int unsigned HOLD = 16;
   localparam int unsigned TMO  = 100;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        pal = 1'b0;
   logic        pll_locked = 1'b1;
   logic        mgmt_waitrequest = 1'b0;
   logic        mgmt_write;
   logic [5:0]  mgmt_address;
   logic [31:0] mgmt_writedata;
   logic        tv_reset;
   logic        busy;
   logic        cur_pal;
   logic        lock_err;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int wait_pct = 0;
   int stall_addr = -1;
   int stall_left = 0;

   typedef struct packed {
      logic [5:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   wr_t exp_e;
   bit  model_cur = 1'b0;
   int  acc_log[$];

   chf_pll_reconfig #(.LOCK_TIMEOUT(TMO), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .pal(pal),
      .pll_locked(pll_locked),
      .mgmt_waitrequest(mgmt_waitrequest),
      .mgmt_write(mgmt_write),
      .mgmt_address(mgmt_address),
      .mgmt_writedata(mgmt_writedata),
      .tv_reset(tv_reset),
      .busy(busy),
      .cur_pal(cur_pal),
      .lock_err(lock_err)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // The six register writes a retune to standard tgt must produce, in order.
   function automatic void push_seq(input bit tgt);
      exp_q.push_back('{6'd0, 32'h0000_0000});
      exp_q.push_back('{6'd3, 32'h0001_0000});
      exp_q.push_back('{6'd4, 32'h0000_0404});
      exp_q.push_back('{6'd5, tgt ? 32'h0002_0504 : 32'h0000_0505});
      exp_q.push_back('{6'd7, tgt ? 32'hA3D7_09E8 : 32'h9745_BF27});
      exp_q.push_back('{6'd2, 32'h0000_0000});
   endfunction

   // Scoreboard: every accepted write pops the model; retunes alternate standard starting from NTSC.
   always @(negedge clk) begin
      if (reset_n && mgmt_write && !mgmt_waitrequest) begin
         if (exp_q.size() == 0) begin
            model_cur = ~model_cur;
            push_seq(model_cur);
         end
         exp_e = exp_q.pop_front();
         check("wr_addr", 32'(mgmt_address), 32'(exp_e.addr));
         check("wr_data", mgmt_writedata, exp_e.data);
         check("wr_tv_reset", 32'(tv_reset), 32'd1);
         acc_log.push_back(cyc);
      end
   end

   // waitrequest: forced stall on one address when armed, otherwise random.
   initial forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && mgmt_write && int'(mgmt_address) == stall_addr) begin
         mgmt_waitrequest = 1'b1;
         stall_left--;
      end else begin
         mgmt_waitrequest = ($urandom_range(99) < wait_pct);
      end
   end

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
      $fatal(1, "watchdog");
   end

   task automatic wait_idle(input string tag, input int max_cyc);
      int quiet = 0;
      for (int i = 0; i < max_cyc && quiet < 6; i++) begin
         @(negedge clk);
         quiet = busy ? 0 : quiet + 1;
      end
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_acc(input int n, input int max_cyc, input string tag);
      int i = 0;
      while (acc_log.size() < n && i < max_cyc) begin
         @(negedge clk);
         i++;
      end
      check({tag, "_acc"}, acc_log.size(), n);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_write"}, 32'(mgmt_write), 32'd0);
      check({tag, "_addr"}, 32'(mgmt_address), 32'd0);
      check({tag, "_data"}, mgmt_writedata, 32'd0);
      check({tag, "_tv"}, 32'(tv_reset), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_cur"}, 32'(cur_pal), 32'd0);
      check({tag, "_err"}, 32'(lock_err), 32'd0);
   endtask

   initial begin
      int t0, first_wr, first_tv, tv_fall, fall_ref, n5, n_w, n_b, n_t;
`ifdef CHF_PLLCFG_LOCK_WAIT_EN
      int tl, t_err;
`endif

      // Reset state
      repeat (3) @(posedge clk);
      #2;
      check_reset_values("rst");
      @(posedge clk);
      #5 reset_n = 1'b1;

      // Quiet: pal steady at NTSC for 1000 cycles with random waitrequest
      wait_pct = 50;
      n_w = 0; n_b = 0; n_t = 0;
      repeat (1000) begin
         @(negedge clk);
         n_w += int'(mgmt_write);
         n_b += int'(busy);
         n_t += int'(tv_reset);
      end
      check("quiet_write", n_w, 0);
      check("quiet_busy", n_b, 0);
      check("quiet_tv", n_t, 0);

      // NTSC -> PAL, no wait states: latency, back-to-back writes, tv_reset window
      wait_pct = 0;
      acc_log.delete();
      @(posedge clk);
      #1 pal = 1'b1;
      t0 = cyc;
      first_wr = -1;
      first_tv = -1;
      for (int i = 0; i < 20 && first_wr < 0; i++) begin
         @(negedge clk);
         if (tv_reset && first_tv < 0) first_tv = cyc;
         if (mgmt_write) first_wr = cyc;
      end
      check("s2_latency", first_wr - t0, 3);
      check("s2_tv_rise", first_tv, first_wr);
      wait_acc(6, 50, "s2");
      if (acc_log.size() >= 6)
         for (int i = 1; i < 6; i++) check("s2_b2b", acc_log[i] - acc_log[i-1], 1);
`ifdef CHF_PLLCFG_LOCK_WAIT_EN
      repeat (5) @(posedge clk);
      #1 pll_locked = 1'b0;
      repeat (50) @(posedge clk);
      #1 pll_locked = 1'b1;
      tl = cyc;
      fall_ref = tl + 3 + int'(HOLD);
`else
      fall_ref = (acc_log.size() >= 6) ? acc_log[5] + 1 + int'(HOLD) : -2;
`endif
      tv_fall = -1;
      for (int i = 0; i < 400 && tv_fall < 0; i++) begin
         @(negedge clk);
         if (!tv_reset) tv_fall = cyc;
      end
      check("s2_tv_fall", tv_fall, fall_ref);
      wait_idle("s2", 500);
      check("s2_cur_pal", 32'(cur_pal), 32'd1);
      check("s2_lock_err", 32'(lock_err), 32'd0);
      check("s2_done", exp_q.size(), 0);

      // PAL -> NTSC with a 7-cycle stall on the C0 write
      acc_log.delete();
      @(posedge clk);
      #1;
      stall_addr = 5;
      stall_left = 7;
      pal = 1'b0;
      n5 = 0;
      for (int i = 0; i < 200 && acc_log.size() < 6; i++) begin
         @(negedge clk);
         if (mgmt_write && mgmt_address == 6'd5) begin
            n5++;
            check("s3_c0_data", mgmt_writedata, 32'h0000_0505);
         end
      end
      check("s3_c0_cycles", n5, 8);
      check("s3_acc", acc_log.size(), 6);
      if (acc_log.size() >= 6) begin
         check("s3_c0_gap", acc_log[3] - acc_log[2], 8);
         check("s3_after_c0", acc_log[4] - acc_log[3], 1);
      end
      wait_idle("s3", 500);
      check("s3_cur_pal", 32'(cur_pal), 32'd0);
      check("s3_done", exp_q.size(), 0);

      // pal flips back mid-sequence: PAL completes, then a fresh NTSC retune
      acc_log.delete();
      @(posedge clk);
      #1 pal = 1'b1;
      wait_acc(6, 50, "s4");
      repeat (4) @(posedge clk);
      #1 pal = 1'b0;
      wait_idle("s4", 1000);
      check("s4_total_writes", acc_log.size(), 12);
      check("s4_cur_pal", 32'(cur_pal), 32'd0);
      check("s4_done", exp_q.size(), 0);

`ifdef CHF_PLLCFG_LOCK_WAIT_EN
      // Lock never returns: timeout, sticky lock_err, HOLD still runs
      acc_log.delete();
      @(posedge clk);
      #1;
      pll_locked = 1'b0;
      pal = 1'b1;
      wait_acc(6, 50, "s5");
      t_err = -1;
      for (int i = 0; i < 300 && t_err < 0; i++) begin
         @(negedge clk);
         if (lock_err) t_err = cyc;
      end
      if (acc_log.size() >= 6) check("s5_err_time", t_err - acc_log[5], 102);
      wait_idle("s5", 500);
      check("s5_err_sticky", 32'(lock_err), 32'd1);
      check("s5_cur_pal", 32'(cur_pal), 32'd1);
      @(posedge clk);
      #1 pll_locked = 1'b1;
`endif

      // Random pal bursts with random waitrequest; last value must win
      wait_pct = 30;
      for (int it = 0; it < 8; it++) begin
         repeat ($urandom_range(1, 3)) begin
            repeat ($urandom_range(0, 40)) @(posedge clk);
            #1 pal = ~pal;
         end
         wait_idle("rnd", 3000);
         check("rnd_cur_pal", 32'(cur_pal), 32'(pal));
         check("rnd_done", exp_q.size(), 0);
      end

      // Reset asserted while the M write is on the bus
      wait_pct = 0;
      @(posedge clk);
      #1;
      pal = 1'b0;
      reset_n = 1'b0;
      exp_q.delete();
      model_cur = 1'b0;
      repeat (3) @(posedge clk);
      #5 reset_n = 1'b1;
      wait_idle("s7a", 100);
      @(posedge clk);
      #1 pal = 1'b1;
      for (int i = 0; i < 30 && !(mgmt_write && mgmt_address == 6'd4); i++) @(negedge clk);
      check("s7_at_m", 32'(mgmt_address), 32'd4);
      #3 reset_n = 1'b0;
      exp_q.delete();
      model_cur = 1'b0;
      #1;
      check_reset_values("s7_rst");
      repeat (3) @(posedge clk);
      #5;
      acc_log.delete();
      reset_n = 1'b1;
      wait_idle("s7", 1000);
      check("s7_restart_writes", acc_log.size(), 6);
      check("s7_cur_pal", 32'(cur_pal), 32'd1);
      check("s7_done", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
